pipeline_hazard_ctrl: RTL and testbench

Scoreboard-based hazard and flush controller for the 8-bit, 4-register pipeline. It sits beside the IF pipeline register and inspects the instruction that register currently presents (opcode, ra, rb). Each cycle it decides whether that instruction issues into ID, stalls with a bubble, or is squashed by a taken branch. It also drives PC advance and freezes everything on a memory wait.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv | 69 ++++++
 rtl/pipeline_hazard_ctrl.sv | 74 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared opcode classes and types for the hazard controller
package pipeline_hazard_ctrl_pkg;

    typedef logic [1:0] reg_idx_t;

    localparam logic [3:0]  OP_NOP     = 4'h0;
    localparam logic [3:0]  OP_ALU_MAX = 4'h7;
    localparam logic [3:0]  OP_LOAD    = 4'h8;
    localparam logic [3:0]  OP_STORE   = 4'h9;
    localparam logic [3:0]  OP_BR_MIN  = 4'hA;
    localparam logic [15:0] NOP_INST   = 16'h0000;

    function automatic logic reads_ra(input logic [3:0] op);
        return ((op != OP_NOP) && (op <= OP_ALU_MAX)) || (op == OP_STORE) || (op >= OP_BR_MIN);
    endfunction

    function automatic logic reads_rb(input logic [3:0] op);
        return (op != OP_NOP) && (op <= OP_ALU_MAX);
    endfunction

    function automatic logic writes_ra(input logic [3:0] op);
        return (op != OP_NOP) && (op <= OP_LOAD);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv - per-register busy countdowns with one-deep shadow for branch cancel
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       cancel,
    input  logic [3:0] opcode,
    input  reg_idx_t   ra,
    input  reg_idx_t   rb,
    output logic       hazard
);

    localparam int BW = $clog2(WB_LAT + 1);
    typedef logic [BW-1:0] cnt_t;

    function automatic cnt_t satdec(input cnt_t x);
        return (x == '0) ? '0 : cnt_t'(x - cnt_t'(1));
    endfunction

    cnt_t     busy     [4];
    cnt_t     busy_nxt [4];
    logic     sh_valid;
    reg_idx_t sh_rd;
    cnt_t     sh_prev;
    logic     issue_we;

    assign hazard = (reads_ra(opcode) && (busy[ra] != '0)) ||
                    (reads_rb(opcode) && (busy[rb] != '0));

    assign issue_we = !cancel && !hazard && writes_ra(opcode);

    // A cancelled ID writer hands its register back to whatever older writer it displaced.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            busy_nxt[i] = satdec(busy[i]);
        end
        if (cancel && sh_valid) begin
            busy_nxt[sh_rd] = satdec(sh_prev);
        end
        if (issue_we) begin
            busy_nxt[ra] = cnt_t'(WB_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                busy[i] <= '0;
            end
            sh_valid <= 1'b0;
            sh_rd    <= '0;
            sh_prev  <= '0;
        end else if (!hold) begin
            for (int i = 0; i < 4; i++) begin
                busy[i] <= busy_nxt[i];
            end
            sh_valid <= issue_we;
            if (issue_we) begin
                sh_rd   <= ra;
                sh_prev <= satdec(busy[ra]);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - issue/stall/flush priority and saturating stall counter
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [15:0]      if_inst,
    input  reg_idx_t         if_ra,
    input  reg_idx_t         if_rb,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             pc_we,
    output logic             if_stall,
    output logic             id_bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [15:0] inst_eff;
    logic [3:0]  opcode;
    logic        hazard;
    logic        unused_inst_bits;

    // An empty IF slot behaves exactly like an issued NOP.
    assign inst_eff         = if_valid ? if_inst : NOP_INST;
    assign opcode           = inst_eff[15:12];
    assign unused_inst_bits = ^inst_eff[11:0];

    hazard_scoreboard #(
        .WB_LAT (WB_LAT)
    ) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_wait),
        .cancel (ex_branch_taken),
        .opcode (opcode),
        .ra     (if_ra),
        .rb     (if_rb),
        .hazard (hazard)
    );

    always_comb begin
        pc_we     = 1'b1;
        if_stall  = 1'b0;
        id_bubble = 1'b0;
        flush     = 1'b0;
        if (rst) begin
            pc_we = 1'b0;
            flush = 1'b1;
        end else if (mem_wait) begin
            pc_we    = 1'b0;
            if_stall = 1'b1;
        end else if (ex_branch_taken) begin
            flush = 1'b1;
        end else if (hazard) begin
            pc_we     = 1'b0;
            if_stall  = 1'b1;
            id_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!mem_wait && !ex_branch_taken && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scenario tables plus randomized run against a register-countdown model
module tb_pipeline_hazard_ctrl;

    localparam int WB_LAT   = 3;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam logic [3:0] C_ISSUE  = 4'b1000;
    localparam logic [3:0] C_STALL  = 4'b0110;
    localparam logic [3:0] C_FLUSH  = 4'b1001;
    localparam logic [3:0] C_FREEZE = 4'b0100;
    localparam logic [3:0] C_RST    = 4'b0001;

    logic             clk;
    logic             rst;
    logic             if_valid;
    logic [15:0]      if_inst;
    logic [1:0]       if_ra;
    logic [1:0]       if_rb;
    logic             ex_branch_taken;
    logic             mem_wait;
    logic             pc_we;
    logic             if_stall;
    logic             id_bubble;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic             r;
        logic             v;
        logic [15:0]      inst;
        logic             br;
        logic             mw;
        logic [3:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } row_t;

    pipeline_hazard_ctrl #(
        .WB_LAT (WB_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_ra           (if_ra),
        .if_rb           (if_rb),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .pc_we           (pc_we),
        .if_stall        (if_stall),
        .id_bubble       (id_bubble),
        .flush           (flush),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t rw(input logic [15:0] inst, input logic br, input logic mw,
                                input logic [3:0] ctl, input int cnt);
        row_t x;
        x = '{1'b0, 1'b1, inst, br, mw, ctl, CNT_W'(cnt)};
        return x;
    endfunction

    task automatic drive(input row_t x);
        @(negedge clk);
        rst             = x.r;
        if_valid        = x.v;
        if_inst         = x.inst;
        if_ra           = x.inst[11:10];
        if_rb           = x.inst[9:8];
        ex_branch_taken = x.br;
        mem_wait        = x.mw;
        #1;
    endtask

    task automatic do_reset();
        drive('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, C_RST, '0});
    endtask

    // Reference model: remaining cycles until each register is readable, and the ID writer's displaced value.
    int mb[4];
    bit mshv;
    int mshrd, mshprev, mcnt;

    function automatic bit m_hazard(input bit v, input logic [15:0] inst);
        int op = int'(inst[15:12]);
        int a  = int'(inst[11:10]);
        int b  = int'(inst[9:8]);
        bit rda = (op >= 1 && op <= 7) || op == 9 || op >= 10;
        bit rdb = (op >= 1 && op <= 7);
        return v && ((rda && mb[a] > 0) || (rdb && mb[b] > 0));
    endfunction

    function automatic logic [3:0] m_ctl(input bit r, input bit v, input logic [15:0] inst,
                                         input bit br, input bit mw);
        if (r)  return C_RST;
        if (mw) return C_FREEZE;
        if (br) return C_FLUSH;
        if (m_hazard(v, inst)) return C_STALL;
        return C_ISSUE;
    endfunction

    task automatic m_commit(input bit r, input bit v, input logic [15:0] inst,
                            input bit br, input bit mw);
        int nb[4];
        int op = int'(inst[15:12]);
        int a  = int'(inst[11:10]);
        bit haz = m_hazard(v, inst);
        for (int i = 0; i < 4; i++) nb[i] = (mb[i] > 0) ? mb[i] - 1 : 0;
        if (r) begin
            for (int i = 0; i < 4; i++) mb[i] = 0;
            mshv = 0; mshrd = 0; mshprev = 0; mcnt = 0;
        end else if (mw) begin
            // frozen
        end else if (br) begin
            if (mshv) nb[mshrd] = (mshprev > 0) ? mshprev - 1 : 0;
            mb = nb;
            mshv = 0;
        end else if (haz) begin
            mb = nb;
            mshv = 0;
            if (mcnt < CNT_MAX) mcnt++;
        end else if (v && op >= 1 && op <= 8) begin
            mshprev = (mb[a] > 0) ? mb[a] - 1 : 0;
            mshrd = a;
            mshv = 1;
            mb = nb;
            mb[a] = WB_LAT;
        end else begin
            mb = nb;
            mshv = 0;
        end
    endtask

    task automatic test_reset();
        row_t q[$];
        do_reset();
        q.push_back('{1'b1, 1'b1, 16'h1100, 1'b0, 1'b0, C_RST, '0});
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 0));
        q.push_back('{1'b1, 1'b1, 16'h1100, 1'b0, 1'b0, C_RST, CNT_W'(1)});
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== q[i].ctl || stall_cnt !== q[i].cnt)
                $display("FAIL reset[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, q[i].ctl, q[i].cnt);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        row_t q[$];
        do_reset();
        q.push_back(rw(16'h1400, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 0));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 1));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 2));
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 3));
        q.push_back('{1'b0, 1'b0, 16'h1100, 1'b0, 1'b0, C_ISSUE, CNT_W'(3)});
        foreach (q[i]) begin
            drive(q[i]);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== q[i].ctl || stall_cnt !== q[i].cnt)
                $display("FAIL back_to_back[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, q[i].ctl, q[i].cnt);
            else n_pass++;
        end
    endtask

    task automatic test_independent();
        logic [15:0] seq[8] = '{16'h1400, 16'h1B00, 16'h9C00, 16'h8000,
                                16'hA400, 16'h0000, 16'h5E00, 16'h9300};
        do_reset();
        foreach (seq[i]) begin
            drive(rw(seq[i], 0, 0, C_ISSUE, 0));
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== C_ISSUE || stall_cnt !== '0)
                $display("FAIL independent[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=0",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, C_ISSUE);
            else n_pass++;
        end
    endtask

    task automatic test_branch_cancel();
        row_t q[$];
        do_reset();
        q.push_back(rw(16'h1400, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h1100, 1, 0, C_FLUSH, 0));
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h1100, 1, 1, C_FREEZE, 0));
        q.push_back(rw(16'h1100, 1, 0, C_FLUSH, 0));
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== q[i].ctl || stall_cnt !== q[i].cnt)
                $display("FAIL branch_cancel[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, q[i].ctl, q[i].cnt);
            else n_pass++;
        end
    endtask

    task automatic test_restore();
        row_t q[$];
        do_reset();
        q.push_back(rw(16'h8400, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h8400, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h0000, 1, 0, C_FLUSH, 0));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 0));
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 1));
        foreach (q[i]) begin
            drive(q[i]);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== q[i].ctl || stall_cnt !== q[i].cnt)
                $display("FAIL restore[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, q[i].ctl, q[i].cnt);
            else n_pass++;
        end
    endtask

    task automatic test_freeze();
        row_t q[$];
        do_reset();
        q.push_back(rw(16'h1400, 0, 0, C_ISSUE, 0));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 0));
        for (int k = 0; k < 5; k++) q.push_back(rw(16'h1100, 0, 1, C_FREEZE, 1));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 1));
        q.push_back(rw(16'h1100, 0, 0, C_STALL, 2));
        q.push_back(rw(16'h1100, 0, 0, C_ISSUE, 3));
        foreach (q[i]) begin
            drive(q[i]);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== q[i].ctl || stall_cnt !== q[i].cnt)
                $display("FAIL freeze[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, q[i].ctl, q[i].cnt);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        row_t q[$];
        int stalls = 0;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            q.push_back(rw(16'h8400, 0, 0, C_ISSUE, (stalls > CNT_MAX) ? CNT_MAX : stalls));
            for (int k = 0; k < 3; k++) begin
                q.push_back(rw(16'h1100, 0, 0, C_STALL, (stalls > CNT_MAX) ? CNT_MAX : stalls));
                stalls++;
            end
            q.push_back(rw(16'h1100, 0, 0, C_ISSUE, (stalls > CNT_MAX) ? CNT_MAX : stalls));
        end
        foreach (q[i]) begin
            drive(q[i]);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== q[i].ctl || stall_cnt !== q[i].cnt)
                $display("FAIL saturation[%0d]: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, {pc_we, if_stall, id_bubble, flush}, stall_cnt, q[i].ctl, q[i].cnt);
            else n_pass++;
        end
        n_total++;
        if (stall_cnt !== CNT_W'(CNT_MAX))
            $display("FAIL saturation_final: cnt=%0d, expected %0d", stall_cnt, CNT_MAX);
        else n_pass++;
    endtask

    task automatic test_random();
        row_t x;
        logic [3:0] exp_ctl;
        do_reset();
        m_commit(1, 0, 16'h0000, 0, 0);
        for (int n = 0; n < 600; n++) begin
            x.r    = ($urandom_range(0, 63) == 0);
            x.v    = ($urandom_range(0, 7) != 0);
            x.inst = 16'($urandom);
            x.br   = ($urandom_range(0, 7) == 0);
            x.mw   = ($urandom_range(0, 7) == 0);
            drive(x);
            exp_ctl = m_ctl(x.r, x.v, x.inst, x.br, x.mw);
            n_total++;
            if ({pc_we, if_stall, id_bubble, flush} !== exp_ctl || stall_cnt !== CNT_W'(mcnt))
                $display("FAIL random[%0d] inst=%h v=%b br=%b mw=%b r=%b: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         n, x.inst, x.v, x.br, x.mw, x.r, {pc_we, if_stall, id_bubble, flush},
                         stall_cnt, exp_ctl, mcnt);
            else n_pass++;
            m_commit(x.r, x.v, x.inst, x.br, x.mw);
        end
    endtask

    initial begin
        rst             = 1'b1;
        if_valid        = 1'b0;
        if_inst         = 16'h0000;
        if_ra           = 2'd0;
        if_rb           = 2'd0;
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_back_to_back();
        test_independent();
        test_branch_cancel();
        test_restore();
        test_freeze();
        test_saturation();
        test_random();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
